// File: rtl/uart_transmitter.sv
// 8N1 UART serializer with a one-entry holding register, paced by baud_tick.
// Define UART_TX_PARITY_EN to insert an even-parity bit after D7 (8E1).
module uart_transmitter (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       baud_tick,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_out,
  output logic       busy,
  output logic       tx_done
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StData  = 3'd2,
    StStop  = 3'd4
  } state_e;
`endif

  state_e     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       tx_out_q, tx_out_d;
  logic [7:0] hold_data_q, hold_data_d;
  logic       hold_full_q, hold_full_d;
  logic       accept;
  logic       load;
`ifdef UART_TX_PARITY_EN
  logic       parity_q, parity_d;
`endif

  assign tx_ready = ~hold_full_q;
  assign tx_out   = tx_out_q;
  assign busy     = (state_q != StIdle);
  assign accept   = tx_valid & ~hold_full_q;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    tx_out_d    = tx_out_q;
    hold_data_d = hold_data_q;
    hold_full_d = hold_full_q;
    load        = 1'b0;
    tx_done     = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d    = parity_q;
`endif

    case (state_q)
      StIdle: begin
        tx_out_d = 1'b1;
        if (baud_tick && hold_full_q) load = 1'b1;
      end
      StStart: begin
        if (baud_tick) begin
          tx_out_d  = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = 3'd0;
          state_d   = StData;
        end
      end
      StData: begin
        if (baud_tick) begin
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx_out_d = parity_q;
            state_d  = StParity;
`else
            tx_out_d = 1'b1;
            state_d  = StStop;
`endif
          end else begin
            tx_out_d  = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (baud_tick) begin
          tx_out_d = 1'b1;
          state_d  = StStop;
        end
      end
`endif
      StStop: begin
        if (baud_tick) begin
          tx_done = 1'b1;
          // Chain straight into the next start bit so back-to-back frames have no gap.
          if (hold_full_q) load = 1'b1;
          else             state_d = StIdle;
        end
      end
      default: begin
        state_d  = StIdle;
        tx_out_d = 1'b1;
      end
    endcase

    if (load) begin
      tx_out_d    = 1'b0;
      shift_d     = hold_data_q;
      state_d     = StStart;
      hold_full_d = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d    = ^hold_data_q;
`endif
    end else if (accept) begin
      hold_full_d = 1'b1;
    end

    if (accept) hold_data_d = tx_data;
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      shift_q     <= 8'h00;
      bit_cnt_q   <= 3'd0;
      tx_out_q    <= 1'b1;
      hold_data_q <= 8'h00;
      hold_full_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_out_q    <= tx_out_d;
      hold_data_q <= hold_data_d;
      hold_full_q <= hold_full_d;
`ifdef UART_TX_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: frame-level model plus directed literal frames.
module tb_uart_transmitter;

`ifdef UART_TX_PARITY_EN
  localparam int FrameTicks = 11;
`else
  localparam int FrameTicks = 10;
`endif

  logic       sys_clk = 1'b0;
  logic       reset = 1'b0;
  logic       baud_tick = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       tx_out;
  logic       busy;
  logic       tx_done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  uart_transmitter dut (
    .sys_clk  (sys_clk),
    .reset    (reset),
    .baud_tick(baud_tick),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_out   (tx_out),
    .busy     (busy),
    .tx_done  (tx_done)
  );

  always #5 sys_clk = ~sys_clk;

  // One-cycle tick every 16 clocks.
  initial begin
    forever begin
      repeat (15) @(posedge sys_clk);
      #1 baud_tick = 1'b1;
      @(posedge sys_clk);
      #1 baud_tick = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: the line carries a queue of bits, one popped per tick.
  logic       m_full = 1'b0;
  logic [7:0] m_hold = 8'h00;
  logic       m_active = 1'b0;
  logic       m_cur = 1'b1;
  logic       m_bits[$];
  logic [7:0] m_log[$];

  always @(posedge sys_clk or posedge reset) begin
    logic acc;
    if (reset) begin
      m_full   = 1'b0;
      m_active = 1'b0;
      m_cur    = 1'b1;
      m_bits.delete();
    end else begin
      acc = tx_valid && !m_full;
      if (baud_tick) begin
        if (m_active && m_bits.size() > 0) begin
          m_cur = m_bits.pop_front();
        end else if (m_full) begin
          m_cur    = 1'b0;
          m_active = 1'b1;
          m_full   = 1'b0;
          for (int i = 0; i < 8; i++) m_bits.push_back(m_hold[i]);
`ifdef UART_TX_PARITY_EN
          m_bits.push_back(^m_hold);
`endif
          m_bits.push_back(1'b1);
        end else begin
          m_cur    = 1'b1;
          m_active = 1'b0;
        end
      end
      if (acc) begin
        m_full = 1'b1;
        m_hold = tx_data;
        m_log.push_back(tx_data);
      end
    end
  end

  always @(negedge sys_clk) begin
    logic exp_done;
    exp_done = m_active && (m_bits.size() == 0) && baud_tick;
    check("tx_out", {31'd0, tx_out}, {31'd0, m_cur});
    check("busy", {31'd0, busy}, {31'd0, m_active});
    check("tx_ready", {31'd0, tx_ready}, {31'd0, !m_full});
    check("tx_done", {31'd0, tx_done}, {31'd0, exp_done});
    if (tx_done === 1'b1) done_cnt++;
  end

  logic cap[0:31];
  int   busy_cnt;

  task automatic wait_tick();
    int w = 0;
    do begin
      @(negedge sys_clk);
      w++;
    end while (!baud_tick && w < 64);
    if (!baud_tick) check("tick_timeout", 32'd0, 32'd1);
  endtask

  // Samples the line in the cycle after each of the next n ticks.
  task automatic capture(input int n);
    busy_cnt = 0;
    for (int i = 0; i < n; i++) begin
      wait_tick();
      @(negedge sys_clk);
      cap[i] = tx_out;
      if (busy) busy_cnt++;
    end
  endtask

  // exp is written in time order, first bit leftmost.
  task automatic check_cap(input string name, input logic [31:0] exp, input int n);
    for (int i = 0; i < n; i++)
      check($sformatf("%s_bit%0d", name, i), {31'd0, cap[i]}, {31'd0, exp[n-1-i]});
  endtask

  task automatic send(input logic [7:0] b);
    int w = 0;
    @(posedge sys_clk);
    #1 tx_valid = 1'b1;
    tx_data = b;
    @(negedge sys_clk);
    while (!tx_ready && w < 400) begin
      @(negedge sys_clk);
      w++;
    end
    if (!tx_ready) check("send_timeout", 32'd0, 32'd1);
    @(posedge sys_clk);
    #1 tx_valid = 1'b0;
  endtask

  initial begin
    int d0;
    #200_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    #1 reset = 1'b1;
    repeat (3) @(posedge sys_clk);
    check("rst_tx_out", {31'd0, tx_out}, 32'd1);
    check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_tx_done", {31'd0, tx_done}, 32'd0);
    #1 reset = 1'b0;

    // Single frame from idle.
    d0 = done_cnt;
    send(8'h55);
    capture(FrameTicks + 1);
`ifdef UART_TX_PARITY_EN
    check_cap("f55", 32'b0_10101010_0_1_1, FrameTicks + 1);
`else
    check_cap("f55", 32'b0_10101010_1_1, FrameTicks + 1);
`endif
    check("f55_busy_ticks", busy_cnt, FrameTicks);
    check("f55_done_pulses", done_cnt - d0, 32'd1);

    // Back-to-back frames, second byte offered while the first shifts.
    send(8'hA5);
    fork
      send(8'h3C);
      capture(2 * FrameTicks + 1);
    join
`ifdef UART_TX_PARITY_EN
    check_cap("b2b", 32'b0_10100101_0_1_0_00111100_0_1_1, 2 * FrameTicks + 1);
`else
    check_cap("b2b", 32'b0_10100101_1_0_00111100_1_1, 2 * FrameTicks + 1);
`endif

    // tx_valid held high across four frames.
    m_log.delete();
    d0 = done_cnt;
    @(posedge sys_clk);
    #1 tx_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      int w = 0;
      tx_data = 8'h31 + 8'(k);
      @(negedge sys_clk);
      while (!tx_ready && w < 400) begin
        @(negedge sys_clk);
        w++;
      end
      if (!tx_ready) check("cont_timeout", 32'd0, 32'd1);
      @(posedge sys_clk);
      #1;
    end
    tx_valid = 1'b0;
    repeat (5 * 16 * FrameTicks) @(posedge sys_clk);
    check("cont_count", m_log.size(), 32'd4);
    for (int k = 0; k < 4 && k < m_log.size(); k++)
      check($sformatf("cont_byte%0d", k), {24'd0, m_log[k]}, 32'h31 + k);
    check("cont_done_pulses", done_cnt - d0, 32'd4);

    // Reset during D4 of 0xFF with a second byte pending.
    send(8'hFF);
    #1 tx_valid = 1'b1;
    tx_data = 8'hEE;
    repeat (6) wait_tick();
    @(posedge sys_clk);
    #3 reset = 1'b1;
    tx_valid = 1'b0;
    #1;
    check("mid_rst_tx_out", {31'd0, tx_out}, 32'd1);
    check("mid_rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(posedge sys_clk);
    #1 reset = 1'b0;
    send(8'h00);
    capture(FrameTicks + 1);
`ifdef UART_TX_PARITY_EN
    check_cap("f00", 32'b0_00000000_0_1_1, FrameTicks + 1);
`else
    check_cap("f00", 32'b0_00000000_1_1, FrameTicks + 1);
`endif

`ifdef UART_TX_PARITY_EN
    send(8'h07);
    capture(FrameTicks + 1);
    check_cap("p07", 32'b0_11100000_1_1_1, FrameTicks + 1);
    send(8'h03);
    capture(FrameTicks + 1);
    check_cap("p03", 32'b0_11000000_0_1_1, FrameTicks + 1);
`endif

    // Long idle: line stays high, no activity.
    d0 = done_cnt;
    for (int i = 0; i < 50; i++) begin
      wait_tick();
      @(negedge sys_clk);
      check("idle_tx_out", {31'd0, tx_out}, 32'd1);
      check("idle_busy", {31'd0, busy}, 32'd0);
    end
    check("idle_done_pulses", done_cnt - d0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
